next_pc_predict: RTL and testbench

//  Fetch-stage PC generator for the MIPS core. It generalises the combinational branch/jump next-address unit into a registered PC.

---
 rtl/next_pc_predict_if.sv | 32 +++
 rtl/next_pc_predict.sv | 110 +++++++++++
 tb/tb_next_pc_predict.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/next_pc_predict_if.sv
// Fetch/resolve bus of the next-PC predictor: fetch-side outputs plus the
// EX-stage resolution record used to train the BTB and redirect fetch.
interface next_pc_predict_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic              res_is_branch;
  logic              res_is_jump;
  logic              res_cond;
  logic [31:0]       res_imm;
  logic [25:0]       res_instr_index;
  logic              res_pred_taken;
  logic              flush;

  // Pipeline side: drives stall and resolutions, consumes pc/prediction/flush
  modport master (
    output stall, res_valid, res_pc, res_is_branch, res_is_jump, res_cond,
           res_imm, res_instr_index, res_pred_taken,
    input  pc, pred_taken, flush
  );

  // Predictor side
  modport slave (
    input  stall, res_valid, res_pc, res_is_branch, res_is_jump, res_cond,
           res_imm, res_instr_index, res_pred_taken,
    output pc, pred_taken, flush
  );
endinterface

// File: rtl/next_pc_predict.sv
// Fetch-stage PC register with a direct-mapped BTB (2-bit counters plus a
// jump bit). EX resolutions train the BTB and redirect fetch on mispredict.
module next_pc_predict #(
  parameter int                ADDR_W      = 32,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst,
  next_pc_predict_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Saturating 2-bit direction counter step
  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid [BTB_ENTRIES];
  logic [1:0]        r_cnt   [BTB_ENTRIES];
  logic              r_jmp   [BTB_ENTRIES];
  logic [TAG_W-1:0]  r_tag   [BTB_ENTRIES];
  logic [ADDR_W-1:0] r_tgt   [BTB_ENTRIES];

  // Fetch-side lookup on the current pc (pre-edge BTB contents)
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_pred;

  assign w_f_idx = r_pc[IDX_W+1:2];
  assign w_f_tag = r_pc[ADDR_W-1:IDX_W+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_pred  = w_f_hit && (r_cnt[w_f_idx][1] || r_jmp[w_f_idx]);

  // Resolution-side target and direction
  logic        [ADDR_W-1:0] w_pc4;
  logic signed [ADDR_W-1:0] w_off;
  logic        [ADDR_W-1:0] w_br_tgt;
  logic        [ADDR_W-1:0] w_j_tgt;
  logic        [ADDR_W-1:0] w_act_tgt;
  logic                     w_act_taken;
  logic                     w_res_act;
  logic                     w_mispredict;

  assign w_pc4        = bus.res_pc + ADDR_W'(4);
  assign w_off        = ADDR_W'(signed'(bus.res_imm)) <<< 2;
  assign w_br_tgt     = w_pc4 + w_off;
  assign w_j_tgt      = {w_pc4[ADDR_W-1:28], bus.res_instr_index, 2'b00};
  assign w_act_taken  = bus.res_is_jump || (bus.res_is_branch && bus.res_cond);
  assign w_act_tgt    = bus.res_is_jump ? w_j_tgt : w_br_tgt;
  assign w_res_act    = bus.res_valid && (bus.res_is_branch || bus.res_is_jump);
  assign w_mispredict = w_res_act && (w_act_taken != bus.res_pred_taken);

  // BTB slot addressed by the resolved instruction
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_u_write;

  assign w_u_idx   = bus.res_pc[IDX_W+1:2];
  assign w_u_tag   = bus.res_pc[ADDR_W-1:IDX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  // Target/tag written on jump hits and on taken allocations
  assign w_u_write = w_res_act && (w_u_hit ? bus.res_is_jump : w_act_taken);

  assign bus.pc         = r_pc;
  assign bus.pred_taken = w_pred;
  assign bus.flush      = w_mispredict && !rst;

  // PC register: reset > mispredict redirect > stall hold > BTB target > pc+4
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= RESET_PC;
    else if (w_mispredict)
      r_pc <= w_act_taken ? w_act_tgt : w_pc4;
    else if (!bus.stall)
      r_pc <= w_pred ? r_tgt[w_f_idx] : r_pc + ADDR_W'(4);
  end

  // BTB control state: valid bits and direction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
      end
    end else if (w_res_act) begin
      if (w_u_hit) begin
        if (bus.res_is_jump) r_cnt[w_u_idx] <= 2'b11;
        else                 r_cnt[w_u_idx] <= sat_cnt(r_cnt[w_u_idx], bus.res_cond);
      end else if (w_act_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_cnt[w_u_idx]   <= bus.res_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // BTB payload: tag, target and jump bit (only meaningful while valid)
  always_ff @(posedge clk) begin
    if (w_u_write) begin
      r_tag[w_u_idx] <= w_u_tag;
      r_tgt[w_u_idx] <= w_act_tgt;
      r_jmp[w_u_idx] <= bus.res_is_jump;
    end
  end
endmodule

// File: tb/tb_next_pc_predict.sv
// Randomized and directed bench for next_pc_predict against a table-level
// model of the BTB and fetch address sequence.
module tb_next_pc_predict;
  localparam int NE = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  next_pc_predict_if #(.ADDR_W(32)) bus ();

  next_pc_predict #(.ADDR_W(32), .BTB_ENTRIES(NE), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  bit          m_known = 0;
  bit [31:0]   m_pc;
  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  bit [31:0]   m_tgt   [NE];
  bit          m_jmp   [NE];
  int          m_cnt   [NE];

  bit obs_flush, obs_pt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit t_rst, input bit t_stall, input bit t_rv,
                      input bit t_br, input bit t_jmp, input bit t_cond,
                      input bit [31:0] t_rpc, input bit [31:0] t_imm,
                      input bit [25:0] t_ii, input bit t_rpt);
    bit [31:0] pc4, tgt, npc;
    bit taken, rel, mis, hit, uhit, e_pt;
    int idx, uidx;
    @(negedge clk);
    rst                 = t_rst;
    bus.stall           = t_stall;
    bus.res_valid       = t_rv;
    bus.res_is_branch   = t_br;
    bus.res_is_jump     = t_jmp;
    bus.res_cond        = t_cond;
    bus.res_pc          = t_rpc;
    bus.res_imm         = t_imm;
    bus.res_instr_index = t_ii;
    bus.res_pred_taken  = t_rpt;

    idx   = int'((m_pc / 4) % NE);
    hit   = m_valid[idx] && (m_tag[idx] == m_pc / (4 * NE));
    e_pt  = hit && (m_cnt[idx] >= 2 || m_jmp[idx]);
    pc4   = t_rpc + 32'd4;
    tgt   = t_jmp ? ((pc4 & 32'hF000_0000) | ({6'd0, t_ii} * 32'd4))
                  : (pc4 + t_imm * 32'd4);
    taken = t_jmp || (t_br && t_cond);
    rel   = t_rv && (t_br || t_jmp);
    mis   = rel && (taken != t_rpt);

    #1;
    obs_flush = bus.flush;
    obs_pt    = bus.pred_taken;
    chk("flush", {31'd0, obs_flush}, {31'd0, mis && !t_rst});
    if (m_known) begin
      chk("pred_taken", {31'd0, obs_pt}, {31'd0, e_pt});
      chk("pc_now", bus.pc, m_pc);
    end

    if (t_rst) begin
      npc = 32'h0;
      for (int i = 0; i < NE; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
    end else begin
      if (mis)          npc = taken ? tgt : pc4;
      else if (t_stall) npc = m_pc;
      else if (e_pt)    npc = m_tgt[idx];
      else              npc = m_pc + 32'd4;
      if (rel) begin
        uidx = int'((t_rpc / 4) % NE);
        uhit = m_valid[uidx] && (m_tag[uidx] == t_rpc / (4 * NE));
        if (uhit && t_jmp) begin
          m_cnt[uidx] = 3; m_jmp[uidx] = 1; m_tgt[uidx] = tgt;
        end else if (uhit) begin
          if (t_cond) m_cnt[uidx] = (m_cnt[uidx] < 3) ? m_cnt[uidx] + 1 : 3;
          else        m_cnt[uidx] = (m_cnt[uidx] > 0) ? m_cnt[uidx] - 1 : 0;
        end else if (taken) begin
          m_valid[uidx] = 1; m_tag[uidx] = t_rpc / (4 * NE);
          m_tgt[uidx] = tgt; m_jmp[uidx] = t_jmp; m_cnt[uidx] = t_jmp ? 3 : 2;
        end
      end
    end

    @(posedge clk);
    #1;
    m_pc = npc;
    if (t_rst) m_known = 1;
    if (m_known) chk("pc_next", bus.pc, m_pc);
  endtask

  task automatic idle(input bit s);
    step(0, s, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 0);
  endtask

  task automatic resolve(input bit br, input bit j, input bit c, input bit [31:0] rpc,
                         input bit [31:0] imm, input bit [25:0] ii, input bit rpt);
    step(0, 0, 1, br, j, c, rpc, imm, ii, rpt);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.res_valid = 0; bus.res_is_branch = 0; bus.res_is_jump = 0;
    bus.res_cond = 0; bus.res_pc = '0; bus.res_imm = '0; bus.res_instr_index = '0;
    bus.res_pred_taken = 0;

    // Reset and sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", bus.pc, 32'h0);
    idle(0); chk("seq_pc4", bus.pc, 32'h4);
    idle(0); chk("seq_pc8", bus.pc, 32'h8);
    chk("seq_pred", {31'd0, obs_pt}, 32'd0);
    idle(0); chk("seq_pcC", bus.pc, 32'hC);

    // Taken branch at 0x10 trains the BTB
    resolve(1, 0, 1, 32'h10, 32'd2, 26'h0, 0);
    chk("br_flush", {31'd0, obs_flush}, 32'd1);
    chk("br_redirect", bus.pc, 32'h1C);
    resolve(1, 0, 0, 32'hC, 32'd0, 26'h0, 1);
    chk("to_0x10", bus.pc, 32'h10);
    idle(0);
    chk("br_pred", {31'd0, obs_pt}, 32'd1);
    chk("br_pred_pc", bus.pc, 32'h1C);

    // Jump at 0x20
    resolve(0, 1, 0, 32'h20, 32'd0, 26'h30, 0);
    chk("j_flush", {31'd0, obs_flush}, 32'd1);
    chk("j_redirect", bus.pc, 32'hC0);
    resolve(1, 0, 0, 32'h1C, 32'd0, 26'h0, 1);
    idle(0);
    chk("j_pred", {31'd0, obs_pt}, 32'd1);
    chk("j_pred_pc", bus.pc, 32'hC0);

    // Backward branch, then counter decay on not-taken
    resolve(1, 0, 1, 32'h28, 32'hFFFF_FFFE, 26'h0, 0);
    chk("back_pc", bus.pc, 32'h24);
    resolve(1, 0, 0, 32'h28, 32'hFFFF_FFFE, 26'h0, 1);
    chk("nt_flush", {31'd0, obs_flush}, 32'd1);
    chk("nt_pc", bus.pc, 32'h2C);
    resolve(1, 0, 0, 32'h24, 32'd0, 26'h0, 1);
    idle(0);
    chk("nt_pred", {31'd0, obs_pt}, 32'd0);

    // Alias at same index replaces the 0x10 entry
    resolve(1, 0, 1, 32'h10 + 4 * NE, 32'd0, 26'h0, 0);
    resolve(1, 0, 0, 32'hC, 32'd0, 26'h0, 1);
    idle(0);
    chk("alias_pred", {31'd0, obs_pt}, 32'd0);
    chk("alias_pc", bus.pc, 32'h14);

    // Stall, stall with mispredict, reset with mispredict
    idle(1); chk("stall_hold", bus.pc, 32'h14);
    step(0, 1, 1, 1, 0, 1, 32'h100, 32'd4, 26'h0, 0);
    chk("stall_mis", bus.pc, 32'h114);
    step(1, 0, 1, 1, 0, 1, 32'h100, 32'd4, 26'h0, 0);
    chk("rst_mis_flush", {31'd0, obs_flush}, 32'd0);
    chk("rst_mis_pc", bus.pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           32'($urandom_range(0, 47)) * 32'd4,
           32'($urandom_range(0, 16)) - 32'd8,
           26'($urandom_range(0, 63)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
